run_control: RTL and testbench
==============================

RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 4: the number of consecutive stable synchronized samples required to accept a button level change.
REQ-002 The module SHALL have parameter FAST_DIV, default 2: the cpu_en period in cycles when Fre_Choice=0.
REQ-003 The module SHALL have parameter SLOW_DIV, default 8: the cpu_en period in cycles when Fre_Choice=1.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port stop_button, input, 1 bit: raw, asynchronous run/halt toggle button, active-high.
REQ-007 The module SHALL have port step_button, input, 1 bit: raw, asynchronous single-step button, active-high.
REQ-008 The module SHALL have port Fre_Choice, input, 1 bit: execution rate select; 0 selects FAST_DIV, 1 selects SLOW_DIV.
REQ-009 The module SHALL have port cpu_en, output, 1 bit: one-cycle clock-enable tick consumed by the datapath.
REQ-010 The module SHALL have port running, output, 1 bit: 1 when state=RUN.
REQ-011 The module SHALL have port stop_evt, output, 1 bit: one-cycle pulse on each RUN->HALT transition.
REQ-012 The module SHALL have port state, output, 2 bits: FSM state encoded as RUN=00, HALT=01, STEP=10; 11 is unused.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer holding a stable level and a counter.
REQ-014 The debouncer counter SHALL clear whenever the synchronized sample equals the stable level, and otherwise increment.
REQ-015 The stable level SHALL toggle when the synchronized sample has differed from it for DB_CYCLES consecutive cycles; the counter SHALL clear on that toggle.
REQ-016 A press SHALL be a one-cycle registered pulse on a 0->1 transition of the stable level; a release SHALL generate nothing.
REQ-017 Latency from the first rising edge sampling a raw 1 to the corresponding state register update SHALL be exactly DB_CYCLES+3 cycles.
REQ-018 A raw pulse shorter than DB_CYCLES cycles after synchronization SHALL produce no press.
REQ-019 The FSM SHALL follow these transitions: RUN + stop press -> HALT; HALT + stop press -> RUN; HALT + step press -> STEP; STEP -> HALT on the cycle after its cpu_en tick.
REQ-020 All other events SHALL be ignored: step press in RUN, and both presses in STEP.
REQ-021 When stop and step presses occur in the same cycle in HALT, stop SHALL win and the FSM SHALL go to RUN.
REQ-022 The divider counter SHALL free-run in all states from 0 to DIV-1 and then wrap to 0, where DIV = Fre_Choice ? SLOW_DIV : FAST_DIV.
REQ-023 A divider tick SHALL occur in the cycle where the counter equals DIV-1.
REQ-024 Fre_Choice SHALL be registered; on any change of the registered value, the counter SHALL load 0 on the next edge, and no tick SHALL occur in that cycle.
REQ-025 cpu_en SHALL equal tick AND (state==RUN OR state==STEP), registered so it is glitch-free and exactly one cycle wide.
REQ-026 In STEP, exactly one cpu_en pulse SHALL be issued, at the first tick after STEP is entered.
REQ-027 stop_evt SHALL assert for exactly one cycle, in the cycle after state changes RUN->HALT.
REQ-028 running SHALL be driven combinationally from the state register.

Reset
REQ-029 While RST=1, the module SHALL asynchronously force: state=RUN, running=1, cpu_en=0, stop_evt=0, synchronizers and stable levels=0, debounce counters=0, divider counter=0, registered Fre_Choice=0.
REQ-030 Assertion of RST mid-debounce or in STEP SHALL discard the pending press or step with no residual pulse after release.
REQ-031 After RST deassertion with Fre_Choice=0, the first cpu_en SHALL occur FAST_DIV cycles later; if Fre_Choice=1 at release, the REQ-024 reload applies first.

Verification
REQ-032 The bench SHALL cover: reset release with Fre_Choice=0 -> running=1, state=00, cpu_en high every 2nd cycle.
REQ-033 The bench SHALL cover: stop_button high for 3 cycles -> no state change; then high for 10 cycles -> state=01 exactly 7 cycles after the first sampled 1, stop_evt one pulse, and cpu_en stays 0.
REQ-034 The bench SHALL cover: in HALT, a step_button press -> state 01->10->01, exactly one cpu_en pulse, with no further pulses over 50 cycles.
REQ-035 The bench SHALL cover: in RUN, Fre_Choice changed 0->1 -> one tick-free reload, then cpu_en period 8; changed back -> period 2.
REQ-036 The bench SHALL cover: stop and step pressed together in HALT -> state=00, and no STEP visit.
REQ-037 The bench SHALL cover: RST pulsed 1000 cycles into a held stop_button -> all outputs return to their reset values; after release with the button still held, exactly one HALT transition occurs DB_CYCLES+3 cycles later.

Source files
------------

// File: rtl/run_control.sv
// Run/halt/single-step controller: debounces the stop and step buttons and
// issues a divided cpu_en tick to the datapath while running or stepping.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | 00: free running, cpu_en on every divider tick
// HALT  | 01: stopped, waiting for a stop (resume) or step press
// STEP  | 10: issue one cpu_en on the next tick, then back to HALT
module run_control #(
  parameter int DB_CYCLES = 4,
  parameter int FAST_DIV  = 2,
  parameter int SLOW_DIV  = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       stop_button,
  input  logic       step_button,
  input  logic       Fre_Choice,
  output logic       cpu_en,
  output logic       running,
  output logic       stop_evt,
  output logic [1:0] state
);

  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_HALT = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int DBW     = $clog2(DB_CYCLES + 1);

  localparam logic [CW-1:0]  FAST_LAST = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0]  SLOW_LAST = CW'(SLOW_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);

  // Bit 0 carries the stop button, bit 1 the step button.
  logic [1:0]     btn_raw, sync1, sync2, stable, stable_d, press;
  logic [DBW-1:0] db_cnt [2];
  logic           stop_press, step_press;

  assign btn_raw    = {step_button, stop_button};
  assign stop_press = press[0];
  assign step_press = press[1];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stable[i] <= ~stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A change of the registered rate select restarts the divider without a tick.
  logic          fre_q, fre_q_d, fre_change, tick;
  logic [CW-1:0] div_cnt, div_last;

  assign div_last   = fre_q ? SLOW_LAST : FAST_LAST;
  assign fre_change = fre_q ^ fre_q_d;
  assign tick       = !fre_change && (div_cnt == div_last);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      fre_q   <= 1'b0;
      fre_q_d <= 1'b0;
      div_cnt <= '0;
    end else begin
      fre_q   <= Fre_Choice;
      fre_q_d <= fre_q;
      if (fre_change || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 1'b1;
    end
  end

  logic [1:0] state_next;
  logic       cpu_en_d, stop_evt_d;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= S_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (stop_press) state_next = S_HALT;
      S_HALT: begin
        if (stop_press)      state_next = S_RUN;
        else if (step_press) state_next = S_STEP;
      end
      S_STEP:  if (tick) state_next = S_HALT;
      default: state_next = S_RUN;
    endcase
  end

  always_comb begin
    running    = (state == S_RUN);
    cpu_en_d   = tick && ((state == S_RUN) || (state == S_STEP));
    stop_evt_d = (state == S_RUN) && (state_next == S_HALT);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cpu_en   <= 1'b0;
      stop_evt <= 1'b0;
    end else begin
      cpu_en   <= cpu_en_d;
      stop_evt <= stop_evt_d;
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: cycle-by-cycle comparison against a behavioural
// model, directed scenarios with literal expectations, then random stimulus.
module tb_run_control;

  localparam int DB = 4;
  localparam int FD = 2;
  localparam int SD = 8;

  logic       clk = 1'b0;
  logic       rst, stop_b, step_b, fre;
  logic       cpu_en, running, stop_evt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  run_control #(.DB_CYCLES(DB), .FAST_DIV(FD), .SLOW_DIV(SD)) dut (
    .clk(clk), .RST(rst), .stop_button(stop_b), .step_button(step_b),
    .Fre_Choice(fre), .cpu_en(cpu_en), .running(running),
    .stop_evt(stop_evt), .state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: 0=RUN 1=HALT 2=STEP
  int          m_state;
  bit          m_cpu_en, m_stop_evt;
  bit [1:0]    m_s1, m_s2, m_stable, m_stable_prev, m_press;
  int unsigned m_hist [2];
  bit          m_fre, m_fre_prev;
  int          m_since;

  task automatic model_reset();
    m_state = 0; m_cpu_en = 0; m_stop_evt = 0;
    m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_prev = 0; m_press = 0;
    m_hist[0] = 0; m_hist[1] = 0;
    m_fre = 0; m_fre_prev = 0; m_since = 0;
  endtask

  task automatic model_step();
    int unsigned mask = (32'd1 << DB) - 1;
    int          div = m_fre ? SD : FD;
    bit          tick = (m_fre == m_fre_prev) && ((m_since % div) == div - 1);
    bit [1:0]    new_stable = m_stable;
    int          nst = m_state;
    for (int b = 0; b < 2; b++) begin
      int unsigned w;
      m_hist[b] = (m_hist[b] << 1) | 32'(m_s2[b]);
      w = m_hist[b] & mask;
      // level accepted once the last DB synchronized samples all disagree
      if (m_stable[b] ? (w == 0) : (w == mask)) new_stable[b] = ~m_stable[b];
    end
    case (m_state)
      0: if (m_press[0]) nst = 1;
      1: if (m_press[0]) nst = 0; else if (m_press[1]) nst = 2;
      default: if (tick) nst = 1;
    endcase
    m_cpu_en      = tick && (m_state != 1);
    m_stop_evt    = (m_state == 0) && (nst == 1);
    m_state       = nst;
    m_press       = m_stable & ~m_stable_prev;
    m_stable_prev = m_stable;
    m_stable      = new_stable;
    m_s2          = m_s1;
    m_s1          = {step_b, stop_b};
    m_since       = (m_fre != m_fre_prev) ? 0 : m_since + 1;
    m_fre_prev    = m_fre;
    m_fre         = fre;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("state",    int'(state),    m_state);
        check("running",  int'(running),  int'(m_state == 0));
        check("cpu_en",   int'(cpu_en),   int'(m_cpu_en));
        check("stop_evt", int'(stop_evt), int'(m_stop_evt));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_stop();
    stop_b = 1; cyc(10); stop_b = 0; cyc(20);
  endtask

  initial begin
    int first, cnt, evts, saw_step;
    int pos[$];
    rst = 1; stop_b = 0; step_b = 0; fre = 0;
    cyc(3);
    check("rst_state",    int'(state),    0);
    check("rst_running",  int'(running),  1);
    check("rst_cpu_en",   int'(cpu_en),   0);
    check("rst_stop_evt", int'(stop_evt), 0);
    chk_en = 1;
    #2 rst = 0;

    // fast rate after release: first cpu_en two cycles later, then every 2nd
    first = 0; cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu_en) begin cnt++; if (first == 0) first = k; end
    end
    check("first_cpu_en", first, FD);
    check("fast_count", cnt, 10);

    // too-short press is filtered
    stop_b = 1; cyc(3); stop_b = 0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (state != 2'b00) cnt++; end
    check("short_press_ignored", cnt, 0);

    // 10-cycle press: raw seen at edge 0, state updates on edge DB+3
    stop_b = 1; first = 0; evts = 0; cnt = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 10) stop_b = 0;
      if (state == 2'b01 && first == 0) first = k;
      else if (state == 2'b01 && cpu_en) cnt++;
      if (stop_evt) evts++;
    end
    check("halt_latency", first, DB + 4);
    check("halt_stop_evt", evts, 1);
    check("halt_cpu_en", cnt, 0);

    // single step
    step_b = 1; cnt = 0; saw_step = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 10) step_b = 0;
      if (cpu_en) cnt++;
      if (state == 2'b10) saw_step = 1;
    end
    check("step_pulses", cnt, 1);
    check("step_visited", saw_step, 1);
    check("step_back_halt", int'(state), 1);

    press_stop();
    check("resumed", int'(state), 0);

    // slow rate
    fre = 1; pos.delete();
    for (int k = 1; k <= 60; k++) begin @(negedge clk); if (cpu_en) pos.push_back(k); end
    check("slow_pulses", int'(pos.size() >= 4), 1);
    if (pos.size() >= 4) begin
      check("slow_gap1", pos[2] - pos[1], SD);
      check("slow_gap2", pos[3] - pos[2], SD);
    end
    fre = 0; pos.delete();
    for (int k = 1; k <= 30; k++) begin @(negedge clk); if (cpu_en) pos.push_back(k); end
    check("fast_pulses", int'(pos.size() >= 4), 1);
    if (pos.size() >= 4) check("fast_gap", pos[3] - pos[2], FD);

    // stop and step together in HALT: stop wins
    press_stop();
    check("halted_again", int'(state), 1);
    stop_b = 1; step_b = 1; saw_step = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) begin stop_b = 0; step_b = 0; end
      if (state == 2'b10) saw_step = 1;
    end
    check("both_state", int'(state), 0);
    check("both_no_step", saw_step, 0);

    // reset into a held button
    stop_b = 1; cyc(1000);
    check("held_halt", int'(state), 1);
    #2 rst = 1;
    #1;
    check("mid_rst_state",    int'(state),    0);
    check("mid_rst_running",  int'(running),  1);
    check("mid_rst_cpu_en",   int'(cpu_en),   0);
    check("mid_rst_stop_evt", int'(stop_evt), 0);
    cyc(3);
    #2 rst = 0;
    first = 0; evts = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (state == 2'b01 && first == 0) first = k;
      if (stop_evt) evts++;
    end
    check("rst_halt_latency", first, DB + 4);
    check("rst_halt_count", evts, 1);
    stop_b = 0; cyc(30);

    // random stimulus against the model
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        #2 rst = 1;
        cyc($urandom_range(1, 3));
        #2 rst = 0;
      end else begin
        if (r < 12) fre = ~fre;
        stop_b = ($urandom_range(0, 3) == 0);
        step_b = ($urandom_range(0, 2) == 0);
        cyc($urandom_range(1, 12));
      end
    end
    stop_b = 0; step_b = 0; cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
